// File: rtl/int_action_sched.sv
// int_action_sched: round-robin interrupt grant, action-table snapshot and
// valid/ack/done hand-off of the selected command to the layer controller.
module int_action_sched #(
    parameter int LC_INT_DEPTH = 13
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [LC_INT_DEPTH-1:0]     INT_VECTOR,
    input  logic [4*LC_INT_DEPTH-1:0]   INT_FUNC_ID,
    input  logic [96*LC_INT_DEPTH-1:0]  INT_PAYLOAD,
    input  logic [2*LC_INT_DEPTH-1:0]   INT_CMD_LEN,
    output logic                        CMD_VALID,
    output logic [3:0]                  CMD_FUNC_ID,
    output logic [95:0]                 CMD_PAYLOAD,
    output logic [1:0]                  CMD_LEN,
    input  logic                        CMD_ACK,
    input  logic                        CMD_DONE,
    output logic                        WAKEUP_REQ,
    output logic [LC_INT_DEPTH-1:0]     CLR_INT,
    output logic                        BUSY
);

    localparam int FUNC_WIDTH = 4;
    localparam int DATA_WIDTH = 32;
    localparam int PLD_WIDTH  = 3 * DATA_WIDTH;
    localparam int IDX_W      = (LC_INT_DEPTH > 1) ? $clog2(LC_INT_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_WAKE      = 3'd3,
        S_CLEAR     = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        sel_idx_q, sel_idx_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic [FUNC_WIDTH-1:0]   cmd_func_q, cmd_func_d;
    logic [PLD_WIDTH-1:0]    cmd_payload_q, cmd_payload_d;
    logic [1:0]              cmd_len_q, cmd_len_d;
    logic                    wakeup_q, wakeup_d;
    logic [LC_INT_DEPTH-1:0] clr_int_q, clr_int_d;
    logic                    busy_q, busy_d;

    logic                    grant_vld;
    logic [IDX_W-1:0]        grant_idx;
    logic [FUNC_WIDTH-1:0]   grant_func;
    logic [PLD_WIDTH-1:0]    grant_payload;
    logic [1:0]              grant_len;

    // Round-robin search: first pending bit at or above rr_ptr, wrapping at the top
    always_comb begin
        int j;
        j         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < LC_INT_DEPTH; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= LC_INT_DEPTH) j = j - LC_INT_DEPTH;
            if (!grant_vld && INT_VECTOR[j]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    // Pull the granted entry out of the flattened action table
    always_comb begin
        int g;
        g             = int'(grant_idx);
        grant_func    = INT_FUNC_ID[g*FUNC_WIDTH +: FUNC_WIDTH];
        grant_payload = INT_PAYLOAD[g*PLD_WIDTH +: PLD_WIDTH];
        grant_len     = INT_CMD_LEN[g*2 +: 2];
    end

    // Next-state and next-output logic; every output is a flop so it is set up one cycle ahead
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        sel_idx_d     = sel_idx_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_func_d    = cmd_func_q;
        cmd_payload_d = cmd_payload_q;
        cmd_len_d     = cmd_len_q;
        wakeup_d      = 1'b0;
        clr_int_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    // Snapshot: nothing from the table is looked at again until the next IDLE
                    sel_idx_d     = grant_idx;
                    cmd_func_d    = grant_func;
                    cmd_payload_d = grant_payload;
                    cmd_len_d     = grant_len;
                    if (grant_len == 2'd0) begin
                        state_d  = S_WAKE;
                        wakeup_d = 1'b1;
                    end else begin
                        state_d     = S_ISSUE;
                        cmd_valid_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (CMD_ACK) begin
                    cmd_valid_d = 1'b0;
                    if (CMD_DONE) begin
                        state_d            = S_CLEAR;
                        clr_int_d[sel_idx_q] = 1'b1;
                    end else begin
                        state_d = S_WAIT_DONE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (CMD_DONE) begin
                    state_d              = S_CLEAR;
                    clr_int_d[sel_idx_q] = 1'b1;
                end
            end
            S_WAKE: begin
                state_d              = S_CLEAR;
                clr_int_d[sel_idx_q] = 1'b1;
            end
            S_CLEAR: begin
                state_d  = S_IDLE;
                rr_ptr_d = (sel_idx_q == IDX_W'(LC_INT_DEPTH - 1)) ? '0 : sel_idx_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any in-flight command without a clear
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            sel_idx_q     <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_func_q    <= '0;
            cmd_payload_q <= '0;
            cmd_len_q     <= '0;
            wakeup_q      <= 1'b0;
            clr_int_q     <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            sel_idx_q     <= sel_idx_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_func_q    <= cmd_func_d;
            cmd_payload_q <= cmd_payload_d;
            cmd_len_q     <= cmd_len_d;
            wakeup_q      <= wakeup_d;
            clr_int_q     <= clr_int_d;
            busy_q        <= busy_d;
        end
    end

    assign CMD_VALID   = cmd_valid_q;
    assign CMD_FUNC_ID = cmd_func_q;
    assign CMD_PAYLOAD = cmd_payload_q;
    assign CMD_LEN     = cmd_len_q;
    assign WAKEUP_REQ  = wakeup_q;
    assign CLR_INT     = clr_int_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_int_action_sched.sv
// Directed bench for int_action_sched: expected actions are queued when a
// request is raised and compared as the scheduler services them.
module tb_int_action_sched;

    localparam int N = 13;

    logic          clk = 1'b0;
    logic          RESET;
    logic [N-1:0]  INT_VECTOR;
    logic [4*N-1:0]  INT_FUNC_ID;
    logic [96*N-1:0] INT_PAYLOAD;
    logic [2*N-1:0]  INT_CMD_LEN;
    logic          CMD_VALID;
    logic [3:0]    CMD_FUNC_ID;
    logic [95:0]   CMD_PAYLOAD;
    logic [1:0]    CMD_LEN;
    logic          CMD_ACK;
    logic          CMD_DONE;
    logic          WAKEUP_REQ;
    logic [N-1:0]  CLR_INT;
    logic          BUSY;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          idx;
        logic        wake;
        logic [3:0]  func;
        logic [95:0] payload;
        logic [1:0]  len;
    } exp_t;

    exp_t sb[$];

    int_action_sched #(.LC_INT_DEPTH(N)) dut (
        .CLK         (clk),
        .RESET       (RESET),
        .INT_VECTOR  (INT_VECTOR),
        .INT_FUNC_ID (INT_FUNC_ID),
        .INT_PAYLOAD (INT_PAYLOAD),
        .INT_CMD_LEN (INT_CMD_LEN),
        .CMD_VALID   (CMD_VALID),
        .CMD_FUNC_ID (CMD_FUNC_ID),
        .CMD_PAYLOAD (CMD_PAYLOAD),
        .CMD_LEN     (CMD_LEN),
        .CMD_ACK     (CMD_ACK),
        .CMD_DONE    (CMD_DONE),
        .WAKEUP_REQ  (WAKEUP_REQ),
        .CLR_INT     (CLR_INT),
        .BUSY        (BUSY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_entry(input int i, input logic [3:0] f, input logic [95:0] p, input logic [1:0] l);
        INT_FUNC_ID[i*4 +: 4]   = f;
        INT_PAYLOAD[i*96 +: 96] = p;
        INT_CMD_LEN[i*2 +: 2]   = l;
    endtask

    // Raise a request and queue what its service must look like
    task automatic expect_req(input int i, input logic [3:0] f, input logic [95:0] p, input logic [1:0] l);
        exp_t e;
        set_entry(i, f, p, l);
        e.idx = i; e.wake = (l == 2'd0); e.func = f; e.payload = p; e.len = l;
        sb.push_back(e);
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Service the oldest expected action; called at a negedge with ACK/DONE low
    task automatic serve(input int ack_wait, input int done_wait, input bit same, input bit toggle);
        exp_t e;
        int   n;
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
            return;
        end
        e = sb.pop_front();
        n = 0;
        while (!(CMD_VALID || WAKEUP_REQ) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", (n < 40), 1);
        if (n >= 40) return;
        chk("busy_on", BUSY, 1);
        chk("clr_quiet", CLR_INT, 0);
        if (e.wake) begin
            chk("wake_pulse", WAKEUP_REQ, 1);
            chk("wake_no_valid", CMD_VALID, 0);
            @(negedge clk);
            chk("wake_one_cycle", WAKEUP_REQ, 0);
            chk("wake_no_valid2", CMD_VALID, 0);
        end else begin
            for (int k = 0; k <= ack_wait; k++) begin
                chk("valid_hold", CMD_VALID, 1);
                chk("cmd_func", CMD_FUNC_ID, e.func);
                chk("cmd_len", CMD_LEN, e.len);
                chk("cmd_payload", CMD_PAYLOAD, e.payload);
                if (toggle && k < ack_wait)
                    set_entry(e.idx, ~e.func ^ 4'(k), ~e.payload ^ 96'(k), e.len ^ 2'b11);
                if (k == ack_wait) begin
                    CMD_ACK  = 1'b1;
                    CMD_DONE = same;
                end
                @(negedge clk);
            end
            CMD_ACK  = 1'b0;
            CMD_DONE = 1'b0;
            chk("valid_drop_after_ack", CMD_VALID, 0);
            if (!same) begin
                for (int k = 1; k < done_wait; k++) begin
                    chk("clr_before_done", CLR_INT, 0);
                    @(negedge clk);
                end
                chk("clr_before_done", CLR_INT, 0);
                CMD_DONE = 1'b1;
                @(negedge clk);
                CMD_DONE = 1'b0;
            end
        end
        chk("clr_pulse", CLR_INT, onehot(e.idx));
        INT_VECTOR[e.idx] = 1'b0;
        @(negedge clk);
        chk("clr_one_cycle", CLR_INT, 0);
        chk("busy_idle_gap", BUSY, 0);
    endtask

    initial begin
        RESET       = 1'b1;
        INT_VECTOR  = '0;
        INT_FUNC_ID = '0;
        INT_PAYLOAD = '0;
        INT_CMD_LEN = '0;
        CMD_ACK     = 1'b0;
        CMD_DONE    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", CMD_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_clr", CLR_INT, 0);
        chk("rst_wake", WAKEUP_REQ, 0);
        chk("rst_len", CMD_LEN, 0);
        RESET = 1'b0;
        @(negedge clk);

        // Single request, 1-cycle grant latency, DONE two cycles after ACK
        expect_req(0, 4'h1, 96'h0, 2'd1);
        INT_VECTOR = 13'h0001;
        @(negedge clk);
        chk("grant_latency", CMD_VALID, 1);
        serve(0, 2, 1'b0, 1'b0);

        // Delayed ACK with entry 5 scribbled during the hold window
        expect_req(5, 4'hA, {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF}, 2'd3);
        INT_VECTOR = onehot(5);
        serve(5, 1, 1'b0, 1'b1);
        set_entry(5, 4'h5, {32'h55555555, 32'hAAAAAAAA, 32'h5A5A5A5A}, 2'd3);

        // Wake-up only on the top source
        expect_req(12, 4'hC, 96'h0, 2'd0);
        INT_VECTOR = onehot(12);
        serve(0, 1, 1'b0, 1'b0);

        // Round robin 0 -> 5 -> 12 with wrap, then 0 ahead of 12
        expect_req(0, 4'h3, {32'h11111111, 32'h22222222, 32'h33333333}, 2'd2);
        expect_req(5, 4'h5, {32'h55555555, 32'hAAAAAAAA, 32'h5A5A5A5A}, 2'd3);
        expect_req(12, 4'hC, 96'h0, 2'd0);
        INT_VECTOR = onehot(0) | onehot(5) | onehot(12);
        serve(1, 1, 1'b0, 1'b0);
        serve(0, 1, 1'b0, 1'b0);
        serve(0, 1, 1'b0, 1'b0);
        expect_req(0, 4'h3, {32'h11111111, 32'h22222222, 32'h33333333}, 2'd2);
        expect_req(12, 4'hC, 96'h0, 2'd0);
        INT_VECTOR = onehot(0) | onehot(12);
        serve(2, 1, 1'b0, 1'b0);
        serve(0, 1, 1'b0, 1'b0);

        // ACK and DONE together go straight to CLEAR
        expect_req(7, 4'h7, {32'h77777777, 32'h0, 32'hFFFFFFFF}, 2'd2);
        INT_VECTOR = onehot(7);
        serve(0, 0, 1'b1, 1'b0);

        // Reset while waiting for DONE on source 3 (rr_ptr is 8 here)
        set_entry(3, 4'h3, {32'hCAFEF00D, 32'h3, 32'h33}, 2'd1);
        INT_VECTOR = onehot(3);
        @(negedge clk);
        chk("pre_rst_valid", CMD_VALID, 1);
        chk("pre_rst_func", CMD_FUNC_ID, 4'h3);
        CMD_ACK = 1'b1;
        @(negedge clk);
        CMD_ACK = 1'b0;
        chk("pre_rst_wait_done", CMD_VALID, 0);
        set_entry(10, 4'hE, {32'h10, 32'h1010, 32'h101010}, 2'd2);
        INT_VECTOR[10] = 1'b1;
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        chk("mid_rst_valid", CMD_VALID, 0);
        chk("mid_rst_func", CMD_FUNC_ID, 0);
        chk("mid_rst_payload", CMD_PAYLOAD, 0);
        chk("mid_rst_len", CMD_LEN, 0);
        chk("mid_rst_wake", WAKEUP_REQ, 0);
        chk("mid_rst_clr", CLR_INT, 0);
        chk("mid_rst_busy", BUSY, 0);
        // With rr_ptr back at 0, source 3 must win over source 10
        expect_req(3, 4'h3, {32'hCAFEF00D, 32'h3, 32'h33}, 2'd1);
        expect_req(10, 4'hE, {32'h10, 32'h1010, 32'h101010}, 2'd2);
        serve(1, 1, 1'b0, 1'b0);
        serve(0, 3, 1'b0, 1'b0);

        chk("scoreboard_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
        chk("final_idle", BUSY, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
